// File: rtl/pin_filter_pkg.sv
// Shared constants and elaboration helpers for the pin deglitch filter.
package pin_filter_pkg;

    localparam int unsigned GCNT_W_DEF = 16;

    // Smallest counter width able to hold 0..thresh-1 (never below one bit).
    function automatic int unsigned min_cnt_w(input int unsigned thresh);
        int unsigned w;
        w = 1;
        while ((64'd1 << w) < 64'(thresh)) w = w + 1;
        return w;
    endfunction

    function automatic bit thresh_ok(input int unsigned thresh, input int unsigned cnt_w);
        return (thresh >= 1) && (cnt_w >= min_cnt_w(thresh));
    endfunction

endpackage

// File: rtl/pin_filter_if.sv
// Pin-side bus of the deglitch filter: raw levels in, filtered levels/strobes out.
interface pin_filter_if
    import pin_filter_pkg::*;
#(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned GCNT_W = GCNT_W_DEF
);
    logic              sample_en;
    logic [WIDTH-1:0]  pin_in;
    logic [WIDTH-1:0]  bypass;
    logic [WIDTH-1:0]  pin_out;
    logic [WIDTH-1:0]  rise;
    logic [WIDTH-1:0]  fall;
    logic [GCNT_W-1:0] glitch_cnt;

    modport master (
        output sample_en, pin_in, bypass,
        input  pin_out, rise, fall, glitch_cnt
    );

    modport slave (
        input  sample_en, pin_in, bypass,
        output pin_out, rise, fall, glitch_cnt
    );
endinterface

// File: rtl/pin_filter_cell.sv
// One pin: stability counter, accepted level, edge strobes and abort flag.
module pin_filter_cell #(
    parameter int unsigned CNT_W    = 4,
    parameter int unsigned THRESH   = 8,
    parameter logic        INIT_BIT = 1'b0
) (
    input  logic clock_160,
    input  logic inp_resn,
    input  logic sample_en,
    input  logic pin_in,
    input  logic bypass,
    output logic pin_out,
    output logic rise,
    output logic fall,
    output logic abort
);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(THRESH - 1);

    logic [CNT_W-1:0] cnt;
    logic             differs;

    assign differs = pin_in ^ pin_out;
    // Run broken by a matching sample; bypassed pins never report aborts.
    assign abort   = sample_en & ~bypass & ~differs & (cnt != '0);

    always_ff @(posedge clock_160) begin
        if (!inp_resn) begin
            pin_out <= INIT_BIT;
            cnt     <= '0;
            rise    <= 1'b0;
            fall    <= 1'b0;
        end else begin
            rise <= 1'b0;
            fall <= 1'b0;
            if (sample_en) begin
                if (bypass) begin
                    pin_out <= pin_in;
                    cnt     <= '0;
                    rise    <= differs & pin_in;
                    fall    <= differs & ~pin_in;
                end else if (!differs) begin
                    cnt <= '0;
                end else if (cnt == LAST) begin
                    pin_out <= pin_in;
                    cnt     <= '0;
                    rise    <= pin_in;
                    fall    <= ~pin_in;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end
endmodule

// File: rtl/pin_filter.sv
// Per-pin deglitch/edge-detect array with a shared saturating glitch counter.
module pin_filter
    import pin_filter_pkg::*;
#(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned CNT_W  = 4,
    parameter int unsigned THRESH = 8,
    parameter logic [31:0] INIT   = '0,
    parameter int unsigned GCNT_W = GCNT_W_DEF
) (
    input  logic         clock_160,
    input  logic         inp_resn,
    pin_filter_if.slave  bus
);
    if (!thresh_ok(THRESH, CNT_W)) begin : g_thresh_chk
        $error("pin_filter: THRESH must be in 1..2**CNT_W");
    end

    localparam logic [WIDTH+31:0] INIT_EXT = {{WIDTH{1'b0}}, INIT};

    logic [WIDTH-1:0] abort;
    logic [WIDTH-1:0] pin_out_w;
    logic [WIDTH-1:0] rise_w;
    logic [WIDTH-1:0] fall_w;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        pin_filter_cell #(
            .CNT_W    (CNT_W),
            .THRESH   (THRESH),
            .INIT_BIT (INIT_EXT[i])
        ) u_cell (
            .clock_160 (clock_160),
            .inp_resn  (inp_resn),
            .sample_en (bus.sample_en),
            .pin_in    (bus.pin_in[i]),
            .bypass    (bus.bypass[i]),
            .pin_out   (pin_out_w[i]),
            .rise      (rise_w[i]),
            .fall      (fall_w[i]),
            .abort     (abort[i])
        );
    end

    assign bus.pin_out = pin_out_w;
    assign bus.rise    = rise_w;
    assign bus.fall    = fall_w;

    // One count per cycle no matter how many pins aborted; sticks at all-ones.
    always_ff @(posedge clock_160) begin
        if (!inp_resn) begin
            bus.glitch_cnt <= '0;
        end else if ((|abort) && (bus.glitch_cnt != '1)) begin
            bus.glitch_cnt <= bus.glitch_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_pin_filter.sv
// Randomized and directed checking of pin_filter against a run-length reference model.
module tb_pin_filter;
    localparam int unsigned WIDTH  = 32;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned THRESH = 8;
    localparam int unsigned GCNT_W = 16;
    localparam logic [31:0] INIT_V = 32'h0;
    localparam int          GMAX   = (1 << GCNT_W) - 1;

    logic clock_160 = 1'b0;
    logic inp_resn;

    always #3 clock_160 = ~clock_160;

    pin_filter_if #(.WIDTH(WIDTH), .GCNT_W(GCNT_W)) bus ();

    pin_filter #(
        .WIDTH  (WIDTH),
        .CNT_W  (CNT_W),
        .THRESH (THRESH),
        .INIT   (INIT_V),
        .GCNT_W (GCNT_W)
    ) dut (
        .clock_160 (clock_160),
        .inp_resn  (inp_resn),
        .bus       (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference: accepted level, length of current differing run, strobes, glitch total.
    logic [WIDTH-1:0] m_s;
    logic [WIDTH-1:0] m_rise;
    logic [WIDTH-1:0] m_fall;
    int               m_run [WIDTH];
    int               m_g;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic accept(input int i, input logic lvl);
        if (lvl != m_s[i]) begin
            if (lvl) m_rise[i] = 1'b1;
            else     m_fall[i] = 1'b1;
        end
        m_s[i] = lvl;
    endtask

    task automatic model_step();
        bit aborted;
        m_rise  = '0;
        m_fall  = '0;
        aborted = 0;
        if (!inp_resn) begin
            m_s = INIT_V[WIDTH-1:0];
            for (int i = 0; i < WIDTH; i++) m_run[i] = 0;
            m_g = 0;
        end else if (bus.sample_en) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (bus.bypass[i]) begin
                    accept(i, bus.pin_in[i]);
                    m_run[i] = 0;
                end else if (bus.pin_in[i] == m_s[i]) begin
                    if (m_run[i] > 0) aborted = 1;
                    m_run[i] = 0;
                end else begin
                    m_run[i]++;
                    if (m_run[i] >= THRESH) begin
                        accept(i, bus.pin_in[i]);
                        m_run[i] = 0;
                    end
                end
            end
            if (aborted && m_g < GMAX) m_g++;
        end
    endtask

    task automatic tick();
        @(posedge clock_160);
        model_step();
        #1;
        chk("pin_out",    64'(bus.pin_out),    64'(m_s));
        chk("rise",       64'(bus.rise),       64'(m_rise));
        chk("fall",       64'(bus.fall),       64'(m_fall));
        chk("glitch_cnt", 64'(bus.glitch_cnt), 64'(m_g));
        chk("rise_and_fall", 64'(bus.rise & bus.fall), 64'd0);
    endtask

    task automatic do_reset(input logic [WIDTH-1:0] pins, input int cycles);
        inp_resn      = 1'b0;
        bus.pin_in    = pins;
        bus.bypass    = '0;
        bus.sample_en = 1'b1;
        repeat (cycles) tick();
        inp_resn = 1'b1;
    endtask

    initial begin
        m_s = INIT_V[WIDTH-1:0];
        m_g = 0;
        for (int i = 0; i < WIDTH; i++) m_run[i] = 0;

        // Reset with all pins high, then watch them settle after release.
        do_reset('1, 2);
        repeat (10) tick();

        // Clean single-pin edge.
        do_reset('0, 2);
        bus.pin_in[3] = 1'b1;
        repeat (12) tick();

        // Three-sample glitch on one pin, then simultaneous glitches on two pins.
        bus.pin_in[5] = 1'b1;
        repeat (3) tick();
        bus.pin_in[5] = 1'b0;
        repeat (3) tick();
        bus.pin_in[2:1] = 2'b11;
        repeat (3) tick();
        bus.pin_in[2:1] = 2'b00;
        repeat (3) tick();

        // Sparse sampling with a long disabled gap mid-run.
        bus.pin_in[0] = 1'b1;
        for (int c = 0; c < 48; c++) begin
            bus.sample_en = (c % 4 == 3) && !(c >= 16 && c < 28);
            tick();
        end
        bus.sample_en = 1'b1;

        // Bypassed pin toggling every cycle.
        bus.bypass[7] = 1'b1;
        for (int c = 0; c < 10; c++) begin
            bus.pin_in[7] = ~bus.pin_in[7];
            tick();
        end
        bus.bypass[7] = 1'b0;
        bus.pin_in[7] = bus.pin_out[7];
        repeat (2) tick();

        // Bypass raised mid-count discards the run silently.
        bus.pin_in[9] = 1'b1;
        repeat (4) tick();
        bus.bypass[9] = 1'b1;
        bus.pin_in[9] = 1'b0;
        tick();
        bus.bypass[9] = 1'b0;
        bus.pin_in[9] = 1'b1;
        repeat (10) tick();

        // Randomized traffic with occasional resets, bypass and gating.
        for (int n = 0; n < 3000; n++) begin
            logic [WIDTH-1:0] flip;
            if (n % 64 == 0) bus.bypass = WIDTH'($urandom & $urandom & $urandom);
            flip = (n % 500 < 250) ? WIDTH'($urandom & $urandom & $urandom & $urandom)
                                   : WIDTH'($urandom & $urandom);
            bus.pin_in    = bus.pin_in ^ flip;
            bus.sample_en = ($urandom_range(0, 3) != 0);
            inp_resn      = ($urandom_range(0, 299) != 0);
            tick();
        end

        // Two pins aborting on alternate cycles give one glitch per cycle until saturation.
        do_reset('0, 1);
        for (int c = 0; c < 65600; c++) begin
            bus.pin_in[0] = (c % 2 == 0);
            bus.pin_in[1] = (c % 2 == 1);
            tick();
        end
        chk("glitch_sat", 64'(bus.glitch_cnt), 64'(GMAX));

        // Reset in the middle of a run loses the pending transition.
        bus.pin_in = '0;
        repeat (2) tick();
        bus.pin_in[4] = 1'b1;
        repeat (5) tick();
        inp_resn = 1'b0;
        tick();
        inp_resn = 1'b1;
        repeat (7) tick();
        chk("mid_reset_hold", 64'(bus.pin_out[4]), 64'd0);
        tick();
        chk("mid_reset_rise", 64'(bus.rise[4]), 64'd1);
        repeat (2) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
